map_rom_arbiter: RTL and testbench

//  Shares the single-port synchronous map ROM (21 rows x 30 bits, one row per tile row) between two

---
 rtl/map_rom_arbiter.sv | 82 ++++++++
 tb/tb_map_rom_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/map_rom_arbiter.sv
// map_rom_arbiter: shares one synchronous map ROM between the video pipeline (priority)
// and game logic, with a starvation counter that force-grants the game port.
module map_rom_arbiter #(
  parameter int DEPTH      = 21,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 30,
  parameter int STARVE_MAX = 7
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              vid_req_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic              vid_valid_o,
  output logic [DATA_W-1:0] vid_data_o,
  output logic              vid_miss_o,
  input  logic              gm_req_i,
  input  logic [ADDR_W-1:0] gm_addr_i,
  output logic              gm_ack_o,
  output logic              gm_valid_o,
  output logic [DATA_W-1:0] gm_data_o,
  output logic              gm_oor_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i
);
  typedef enum logic [1:0] {IDLE, VID, GAME} tag_e;
  localparam logic [7:0]      SMAX = 8'(STARVE_MAX);
  localparam logic [ADDR_W:0] DEP  = (ADDR_W+1)'(DEPTH);
  tag_e              tag0_q, tag0_d, tag1_q;
  logic              oor0_q, oor0_d, oor1_q, force_gm;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d, sel_addr;
  logic [7:0]        wait_q, wait_d;
  logic              vid_miss_q, vid_valid_q, gm_valid_q, gm_oor_q;
  logic [DATA_W-1:0] vid_data_q, gm_data_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag0_q      <= IDLE;
      tag1_q      <= IDLE;
      oor0_q      <= 1'b0;
      oor1_q      <= 1'b0;
      rom_addr_q  <= '0;
      wait_q      <= '0;
      vid_miss_q  <= 1'b0;
      vid_valid_q <= 1'b0;
      gm_valid_q  <= 1'b0;
      gm_oor_q    <= 1'b0;
      vid_data_q  <= '0;
      gm_data_q   <= '0;
    end else begin
      tag0_q      <= tag0_d;
      tag1_q      <= tag0_q;
      oor0_q      <= oor0_d;
      oor1_q      <= oor0_q;
      rom_addr_q  <= rom_addr_d;
      wait_q      <= wait_d;
      vid_miss_q  <= force_gm && vid_req_i;
      vid_valid_q <= tag1_q == VID;
      gm_valid_q  <= tag1_q == GAME;
      gm_oor_q    <= tag1_q == GAME && oor1_q;
      if (tag1_q == VID) vid_data_q <= oor1_q ? '0 : rom_data_i;
      if (tag1_q == GAME) gm_data_q <= oor1_q ? '0 : rom_data_i;
    end
  end
  // Out-of-range rows read ROM row 0; the oor tag later zeroes the returned data.
  always_comb begin
    force_gm   = gm_req_i && wait_q == SMAX;
    tag0_d     = force_gm ? GAME : vid_req_i ? VID : gm_req_i ? GAME : IDLE;
    sel_addr   = tag0_d == GAME ? gm_addr_i : vid_addr_i;
    oor0_d     = {1'b0, sel_addr} >= DEP;
    rom_addr_d = tag0_d == IDLE ? rom_addr_q : oor0_d ? '0 : sel_addr;
    wait_d     = (!gm_req_i || tag0_d == GAME) ? '0 : wait_q == SMAX ? wait_q : wait_q + 8'd1;
  end
  always_comb begin
    gm_ack_o    = tag0_q == GAME;
    vid_miss_o  = vid_miss_q;
    vid_valid_o = vid_valid_q;
    vid_data_o  = vid_data_q;
    gm_valid_o  = gm_valid_q;
    gm_data_o   = gm_data_q;
    gm_oor_o    = gm_oor_q;
    rom_addr_o  = rom_addr_q;
  end
endmodule

// File: tb/tb_map_rom_arbiter.sv
// tb_map_rom_arbiter: directed and random checks of map_rom_arbiter against a
// request-level model (priority rules, starvation count, two-cycle return queue).
module tb_map_rom_arbiter;
  localparam int DEPTH = 21, SMAX = 7;
  typedef struct {int kind; int addr;} req_t;
  logic clk = 0, rst_n = 0;
  logic vid_req = 0, gm_req = 0;
  logic [4:0] vid_addr = 0, gm_addr = 0, rom_addr;
  logic vid_valid, vid_miss, gm_ack, gm_valid, gm_oor;
  logic [29:0] vid_data, gm_data, rom_data = 0;
  logic [29:0] rom [32];
  int n_chk = 0, n_fail = 0;
  int mw = 0, e_rom = 0, e_ack = 0, e_miss = 0, e_vv = 0, e_gv = 0, e_oor = 0;
  logic [29:0] e_vd = 0, e_gd = 0;
  req_t pipe[$];

  map_rom_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .vid_req_i(vid_req), .vid_addr_i(vid_addr), .vid_valid_o(vid_valid),
    .vid_data_o(vid_data), .vid_miss_o(vid_miss),
    .gm_req_i(gm_req), .gm_addr_i(gm_addr), .gm_ack_o(gm_ack),
    .gm_valid_o(gm_valid), .gm_data_o(gm_data), .gm_oor_o(gm_oor),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [29:0] row(int a);
    return a >= DEPTH ? 30'd0 : rom[a];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("rom_addr", 32'(rom_addr), 32'(e_rom));
    chk("vid_valid", 32'(vid_valid), 32'(e_vv));
    chk("vid_data", 32'(vid_data), 32'(e_vd));
    chk("vid_miss", 32'(vid_miss), 32'(e_miss));
    chk("gm_ack", 32'(gm_ack), 32'(e_ack));
    chk("gm_valid", 32'(gm_valid), 32'(e_gv));
    chk("gm_data", 32'(gm_data), 32'(e_gd));
    chk("gm_oor", 32'(gm_oor), 32'(e_oor));
  endtask

  task automatic model_reset();
    pipe.delete();
    mw = 0; e_rom = 0; e_ack = 0; e_miss = 0; e_vv = 0; e_gv = 0; e_oor = 0;
    e_vd = 0; e_gd = 0;
  endtask

  task automatic step();
    int kind, nw;
    bit frc;
    req_t r, done;
    frc  = gm_req && mw == SMAX;
    kind = frc ? 2 : vid_req ? 1 : gm_req ? 2 : 0;
    r.kind = kind;
    r.addr = kind == 2 ? int'(gm_addr) : int'(vid_addr);
    nw = (!gm_req || kind == 2) ? 0 : (mw < SMAX ? mw + 1 : SMAX);
    e_miss = frc && vid_req;
    @(posedge clk); #1;
    mw = nw;
    pipe.push_back(r);
    if (kind != 0) e_rom = r.addr < DEPTH ? r.addr : 0;
    e_ack = kind == 2;
    done.kind = 0; done.addr = 0;
    if (pipe.size() == 3) done = pipe.pop_front();
    e_vv = done.kind == 1;
    e_gv = done.kind == 2;
    e_oor = done.kind == 2 && done.addr >= DEPTH;
    if (done.kind == 1) e_vd = row(done.addr);
    if (done.kind == 2) e_gd = row(done.addr);
    check_outputs();
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 32; i++) rom[i] = 30'($urandom);
    // reset held with both requesters active
    vid_req = 1; gm_req = 1; vid_addr = 4; gm_addr = 9;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_outputs();
    end
    vid_req = 0; gm_req = 0;
    rst_n = 1;
    step();
    // video only, row 3
    vid_req = 1; vid_addr = 3;
    step();
    chk("vid_rom_addr3", 32'(rom_addr), 32'd3);
    vid_req = 0;
    step();
    chk("vid_early", 32'(vid_valid), 32'd0);
    step();
    chk("vid_row3", {1'b0, vid_valid, vid_data}, {2'b01, rom[3]});
    step();
    // contention: game wins the 8th edge
    vid_req = 1; vid_addr = 2; gm_req = 1; gm_addr = 5; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      cnt++;
      if (gm_ack) break;
    end
    chk("starve_edges", 32'(cnt), 32'd8);
    chk("starve_miss", 32'(vid_miss), 32'd1);
    gm_req = 0;
    step();
    step();
    chk("starve_row5", {1'b0, gm_valid, gm_data}, {2'b01, rom[5]});
    vid_req = 0;
    step(); step();
    // idle video, last row
    gm_req = 1; gm_addr = 20;
    step();
    chk("row20_ack", 32'(gm_ack), 32'd1);
    gm_req = 0;
    step(); step();
    chk("row20", {gm_oor, gm_valid, gm_data}, {2'b01, rom[20]});
    // out of range
    gm_req = 1; gm_addr = 25;
    step();
    chk("oor_rom_addr", 32'(rom_addr), 32'd0);
    gm_req = 0;
    step(); step();
    chk("oor_data", {gm_oor, gm_valid, gm_data}, {2'b11, 30'd0});
    step();
    // async reset while a game read is in flight
    gm_req = 1; gm_addr = 7;
    step();
    #2 rst_n = 0;
    model_reset();
    #1 check_outputs();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_outputs();
    end
    chk("rst_wait", 32'(dut.wait_q), 32'd0);
    gm_req = 0;
    rst_n = 1;
    step(); step(); step();
    // random traffic with a well-behaved game requester
    for (int i = 0; i < 400; i++) begin
      vid_req = 1'($urandom_range(0, 3) != 0);
      vid_addr = 5'($urandom);
      if (gm_ack || !gm_req) begin
        gm_req = 1'($urandom_range(0, 2) != 0);
        gm_addr = 5'($urandom_range(0, 26));
      end else if ($urandom_range(0, 30) == 0) gm_req = 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
